decoder_simple: RTL and testbench
=================================

Name: decoder_simple

Overview:
- Registered BCD-to-seven-segment decoder for one display digit.
- Converts a 4-bit value into a 7-bit segment pattern.
- Sits between the digit-producing logic (counter/mux) and the display pins.
- Digits 0-9 decode to their glyphs; codes 10-15 blank the digit.

Parameters:
- ACTIVE_LOW, 1, segment polarity. 1 = segment lit by driving 0 (common-anode board default). 0 = segment lit by driving 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset; sampled on rising clk edge.
- entrada_decoder  input  4  unsigned digit code, 0-15.
- salida_decoder  output  7  segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g (bit6..bit0 = g f e d c b a).

Behaviour:
- Single clock domain; single output register for salida_decoder; no other state.
- Latency: a code present on entrada_decoder at rising edge N appears on salida_decoder after edge N. This is 1 cycle; the output is stable for the whole following cycle.
- Reset:
  - When rst=1 at a rising edge, salida_decoder loads the blank pattern (all segments off): 7'h7F if ACTIVE_LOW=1, 7'h00 if ACTIVE_LOW=0.
  - Reset has priority over the input.
  - Reset mid-stream blanks on that edge; decoding resumes on the first edge with rst=0.
- Decode table, ACTIVE_LOW=1, hex of {g..a}:
  - 0 -> 40
  - 1 -> 79
  - 2 -> 24
  - 3 -> 30
  - 4 -> 19
  - 5 -> 12
  - 6 -> 02
  - 7 -> 78
  - 8 -> 00
  - 9 -> 10
- Codes 10-15 -> 7F (blank). No hex glyphs; no error flag.
- ACTIVE_LOW=0: output is the bitwise inverse of the table above, blank included (00).
- Input X/Z: the decoder does not mask it. The bench must not drive X after reset.
- Purely combinational lookup feeding one 7-bit register; no async paths to the output.

Decomposition:
- Shared package seg7_pkg:
  - 7-bit active-high glyph constants SEG_0..SEG_9 (a=bit0).
  - SEG_BLANK = 7'h00.
  - Width constants DIGIT_W=4, SEG_W=7.
  - Polarity is applied in the block by XOR with {7{ACTIVE_LOW}}.
- Optional sub-module seg7_lut: combinational 4-bit -> 7-bit active-high lookup. decoder_simple adds polarity and the output register. Inlining the lookup is equally acceptable.

Test Plan:
- Reset: hold rst=1 for 2 edges with entrada_decoder=8 -> salida_decoder=7'h7F after the first edge; never 00 while rst=1.
- Digit sweep, ACTIVE_LOW=1: apply 0..9 one per cycle after reset release -> 40,79,24,30,19,12,02,78,00,10, each one edge after its input.
- Invalid codes: apply 10, 12, 15 -> 7F each. Then apply 9 -> 10 on the next edge.
- Latency/hold: change the input 3->7 mid-cycle -> output stays 30 until the next rising edge, then 78.
- Reset mid-operation: while showing 5 (12), assert rst for one edge -> 7F. Deassert with input 5 -> 12 on the following edge.
- Polarity, ACTIVE_LOW=0: reset -> 00; apply 0 -> 3F; apply 1 -> 06; apply 8 -> 7F; apply 15 -> 00.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit/segment widths and active-high glyphs.
// Segment order is bit0=a .. bit6=g.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_lut.sv
// Combinational BCD to active-high seven-segment lookup.
// Codes above 9 produce a blank digit.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decoder_simple.sv
// Registered BCD to seven-segment decoder for one display digit.
// The lookup is active-high; board polarity is applied just before the output register.
module decoder_simple
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] entrada_decoder,
    output logic [SEG_W-1:0]   salida_decoder
);

    localparam logic [SEG_W-1:0] POLARITY = {SEG_W{ACTIVE_LOW}};

    logic [SEG_W-1:0] lit;

    seg7_lut u_lut (
        .code (entrada_decoder),
        .seg  (lit)
    );

    // Reset blanks the digit in board polarity and overrides the incoming code.
    always_ff @(posedge clk) begin
        if (rst) begin
            salida_decoder <= SEG_BLANK ^ POLARITY;
        end else begin
            salida_decoder <= lit ^ POLARITY;
        end
    end

endmodule

// File: tb/tb_decoder_simple.sv
// Self-checking bench for decoder_simple: both polarities driven in parallel,
// directed steps followed by random codes checked against a segment-letter model.
module tb_decoder_simple;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] entrada_decoder;
    logic [6:0] salida_low;
    logic [6:0] salida_high;

    int checks   = 0;
    int failures = 0;

    logic [6:0] table_low [16];

    decoder_simple #(.ACTIVE_LOW(1'b1)) dut_low (
        .clk             (clk),
        .rst             (rst),
        .entrada_decoder (entrada_decoder),
        .salida_decoder  (salida_low)
    );

    decoder_simple #(.ACTIVE_LOW(1'b0)) dut_high (
        .clk             (clk),
        .rst             (rst),
        .entrada_decoder (entrada_decoder),
        .salida_decoder  (salida_high)
    );

    always #HALF clk = ~clk;

    // Turns a list of lit segment letters ("abdeg") into an active-high mask.
    function automatic logic [6:0] letters_to_mask(input string s);
        logic [6:0] m;
        m = 7'h00;
        for (int i = 0; i < s.len(); i++) begin
            m[s[i] - "a"] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [6:0] model(input int code, input bit active_low);
        string glyph;
        logic [6:0] lit;
        case (code)
            0: glyph = "abcdef";
            1: glyph = "bc";
            2: glyph = "abdeg";
            3: glyph = "abcdg";
            4: glyph = "bcfg";
            5: glyph = "acdfg";
            6: glyph = "acdefg";
            7: glyph = "abc";
            8: glyph = "abcdefg";
            9: glyph = "abcdfg";
            default: glyph = "";
        endcase
        lit = letters_to_mask(glyph);
        return active_low ? ~lit : lit;
    endfunction

    task automatic checkOutput(input string tag, input logic [6:0] observed,
                               input logic [6:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one input set, then waits past the next rising edge.
    task automatic applyStimulus(input logic [3:0] code, input logic rst_val);
        entrada_decoder = code;
        rst             = rst_val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] code;
        logic       r;
        logic [6:0] exp_low;

        table_low = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

        // Reset held for two edges with an 8 on the input.
        applyStimulus(4'd8, 1'b1);
        checkOutput("reset1_low", salida_low, 7'h7F);
        checkOutput("reset1_high", salida_high, 7'h00);
        applyStimulus(4'd8, 1'b1);
        checkOutput("reset2_low", salida_low, 7'h7F);
        checkOutput("reset2_high", salida_high, 7'h00);

        for (int d = 0; d < 10; d++) begin
            applyStimulus(4'(d), 1'b0);
            checkOutput($sformatf("digit%0d_low", d), salida_low, table_low[d]);
            checkOutput($sformatf("digit%0d_high", d), salida_high, ~table_low[d]);
        end

        applyStimulus(4'd10, 1'b0);
        checkOutput("code10_low", salida_low, 7'h7F);
        checkOutput("code10_high", salida_high, 7'h00);
        applyStimulus(4'd12, 1'b0);
        checkOutput("code12_low", salida_low, 7'h7F);
        applyStimulus(4'd15, 1'b0);
        checkOutput("code15_low", salida_low, 7'h7F);
        checkOutput("code15_high", salida_high, 7'h00);
        applyStimulus(4'd9, 1'b0);
        checkOutput("after_invalid_low", salida_low, 7'h10);

        // Input change mid-cycle must not reach the output before the next edge.
        applyStimulus(4'd3, 1'b0);
        checkOutput("hold_pre_low", salida_low, 7'h30);
        #2 entrada_decoder = 4'd7;
        #1;
        checkOutput("hold_mid_low", salida_low, 7'h30);
        @(posedge clk);
        #1;
        checkOutput("hold_post_low", salida_low, 7'h78);

        applyStimulus(4'd5, 1'b0);
        checkOutput("show5_low", salida_low, 7'h12);
        applyStimulus(4'd5, 1'b1);
        checkOutput("midreset_low", salida_low, 7'h7F);
        checkOutput("midreset_high", salida_high, 7'h00);
        applyStimulus(4'd5, 1'b0);
        checkOutput("resume5_low", salida_low, 7'h12);
        checkOutput("resume5_high", salida_high, 7'h6D);

        applyStimulus(4'd0, 1'b0);
        checkOutput("pol0_high", salida_high, 7'h3F);
        applyStimulus(4'd1, 1'b0);
        checkOutput("pol1_high", salida_high, 7'h06);
        applyStimulus(4'd8, 1'b0);
        checkOutput("pol8_high", salida_high, 7'h7F);
        checkOutput("pol8_low", salida_low, 7'h00);

        for (int i = 0; i < 80; i++) begin
            code = 4'($urandom_range(15, 0));
            r    = ($urandom_range(9, 0) == 0);
            applyStimulus(code, r);
            exp_low = r ? 7'h7F : model(int'(code), 1'b1);
            checkOutput($sformatf("rand%0d_low", i), salida_low, exp_low);
            checkOutput($sformatf("rand%0d_high", i), salida_high,
                        r ? 7'h00 : model(int'(code), 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
